// File: rtl/nn_pkg.sv
// Shared fixed-point types, sequencer state encoding and activation helper
// for the fully-connected layer datapath.
package nn_pkg;

  localparam int FX_W = 32;

  typedef logic signed [FX_W-1:0] fx_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAC   = 3'd1,
    BIAS  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

  function automatic fx_t relu(fx_t x);
    return x[FX_W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/layer_mac_sequencer_mac_unit.sv
// Signed fixed-point multiply-accumulate: full-width product, rescaled by
// FRAC_W bits, accumulated with wrap-around.
module mac_unit
  import nn_pkg::*;
#(
  parameter int DATA_W = FX_W,
  parameter int FRAC_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] acc_o
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [DATA_W-1:0]   scaled;
  logic signed [DATA_W-1:0]   acc_q;
  logic                       unused_prod;

  assign prod        = (2*DATA_W)'(a_i) * (2*DATA_W)'(b_i);
  assign scaled      = prod[FRAC_W+DATA_W-1:FRAC_W];
  // Integer overflow bits and sub-LSB fraction are intentionally discarded.
  assign unused_prod = ^{prod[2*DATA_W-1:FRAC_W+DATA_W], prod[FRAC_W-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + scaled;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/layer_mac_sequencer.sv
// Sequences one fully-connected layer through a single shared MAC, adding bias
// and ReLU per node and handing each result downstream over valid/ready.
module layer_mac_sequencer
  import nn_pkg::*;
#(
  parameter int N_INPUTS = 784,
  parameter int N_NODES  = 16,
  parameter int DATA_W   = FX_W,
  parameter int FRAC_W   = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  abort,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  rd_en,
  output logic [$clog2(N_INPUTS)-1:0]           in_addr,
  output logic [$clog2(N_INPUTS*N_NODES)-1:0]   w_addr,
  output logic [$clog2(N_NODES)-1:0]            b_addr,
  input  logic [DATA_W-1:0]                     in_data,
  input  logic [DATA_W-1:0]                     w_data,
  input  logic [DATA_W-1:0]                     b_data,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic [$clog2(N_NODES)-1:0]            res_node,
  output logic [DATA_W-1:0]                     res_data
);

  localparam int IDX_W  = $clog2(N_INPUTS);
  localparam int NODE_W = $clog2(N_NODES);
  localparam int WA_W   = $clog2(N_INPUTS*N_NODES);

  seq_state_e               state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [NODE_W-1:0]        node_q, node_d;
  logic                     issued_q, issued_d;
  logic                     vld_q;
  logic                     res_valid_q, res_valid_d;
  logic [NODE_W-1:0]        res_node_q, res_node_d;
  logic [DATA_W-1:0]        res_data_q, res_data_d;
  logic                     acc_clr;
  logic signed [DATA_W-1:0] acc;
  logic signed [DATA_W-1:0] biased;

  assign biased = acc + $signed(b_data);

  // issued_q marks that the node's last address is out; the following MAC cycle drains it.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    node_d      = node_q;
    issued_d    = issued_q;
    res_valid_d = res_valid_q;
    res_node_d  = res_node_q;
    res_data_d  = res_data_q;
    rd_en       = 1'b0;
    acc_clr     = 1'b0;
    if (abort) begin
      state_d     = IDLE;
      idx_d       = '0;
      node_d      = '0;
      issued_d    = 1'b0;
      res_valid_d = 1'b0;
      acc_clr     = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d  = MAC;
            idx_d    = '0;
            node_d   = '0;
            issued_d = 1'b0;
            acc_clr  = 1'b1;
          end
        end
        MAC: begin
          if (!issued_q) begin
            rd_en = 1'b1;
            if (idx_q == IDX_W'(N_INPUTS-1)) issued_d = 1'b1;
            else                             idx_d    = idx_q + IDX_W'(1);
          end else begin
            state_d = BIAS;
          end
        end
        BIAS: begin
          res_data_d  = relu(biased);
          res_node_d  = node_q;
          res_valid_d = 1'b1;
          state_d     = WRITE;
        end
        WRITE: begin
          if (res_ready) begin
            res_valid_d = 1'b0;
            if (node_q == NODE_W'(N_NODES-1)) begin
              state_d = DONE;
            end else begin
              node_d   = node_q + NODE_W'(1);
              idx_d    = '0;
              issued_d = 1'b0;
              acc_clr  = 1'b1;
              state_d  = MAC;
            end
          end
        end
        DONE: begin
          state_d  = IDLE;
          idx_d    = '0;
          node_d   = '0;
          issued_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      node_q      <= '0;
      issued_q    <= 1'b0;
      vld_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_node_q  <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      node_q      <= node_d;
      issued_q    <= issued_d;
      vld_q       <= rd_en;
      res_valid_q <= res_valid_d;
      res_node_q  <= res_node_d;
      res_data_q  <= res_data_d;
    end
  end

  mac_unit #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (acc_clr),
    .en_i  (vld_q),
    .a_i   ($signed(in_data)),
    .b_i   ($signed(w_data)),
    .acc_o (acc)
  );

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign in_addr   = idx_q;
  assign w_addr    = WA_W'(node_q) * WA_W'(N_INPUTS) + WA_W'(idx_q);
  assign b_addr    = node_q;
  assign res_valid = res_valid_q;
  assign res_node  = res_node_q;
  assign res_data  = res_data_q;

endmodule
